datapath_seq: RTL and testbench
===============================

# datapath_seq

Parametrised, self-sequencing successor to the 16-bit, 8-register datapath. It holds the register file, the A/B/C operand registers, the B-path shifter, the 4-op ALU and the status register. It also adds an internal micro-sequencer, so one `start` pulse carries a whole read–execute–writeback operation to a one-cycle `done`. It sits between the instruction controller and memory interface; the controller issues one command per instruction instead of driving individual load enables.

## Interface
Parameters:
- `WIDTH`, 16, datapath and register width (≥4)
- `NREGS`, 8, register count; power of two, ≥2; `RW = log2(NREGS)`

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  command request; accepted only when `busy`=0
- `cmd_rn`  in  RW  register read into A
- `cmd_rm`  in  RW  register read into B
- `cmd_rd`  in  RW  destination register
- `cmd_shift`  in  2  B shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- `cmd_aluop`  in  2  00 ADD, 01 SUB, 10 AND, 11 MVN (~Bsh)
- `cmd_asel`  in  1  1: ALU A operand forced to 0
- `cmd_bsel`  in  1  1: ALU B operand = latched `datapath_in`, unshifted
- `cmd_vsel`  in  1  1: immediate write of latched `datapath_in` to `cmd_rd`, no ALU
- `cmd_write`  in  1  1: write result to `cmd_rd`
- `cmd_loads`  in  1  1: update status from this ALU result
- `datapath_in`  in  WIDTH  immediate / memory data
- `busy`  out  1  command in flight
- `done`  out  1  one-cycle completion pulse
- `status`  out  3  {V,N,Z}
- `datapath_out`  out  WIDTH  C register

## Operation
- All `cmd_*` fields and `datapath_in` are latched on the accepting edge. Later input changes have no effect until the next accept.
- FSM states are IDLE, LOADA, LOADB, EXEC, WRITE.
  - IDLE→LOADA on accept when `cmd_vsel`=0.
  - IDLE→WRITE on accept when `cmd_vsel`=1.
  - LOADA→LOADB→EXEC→WRITE unconditionally.
  - WRITE→IDLE.
- LOADA: A ← R[rn]. LOADB: B ← R[rm].
- EXEC:
  - Bsh = shift(B); operands Ain = asel?0:A and Bin = bsel?imm:Bsh.
  - C ← ALU(Ain, Bin).
  - If loads=1, status ← flags.
- WRITE:
  - If vsel=1, R[rd] ← imm and C is unchanged.
  - If vsel=0, R[rd] ← C, but only when write=1.
  - Status is never updated on a vsel=1 command.
- Arithmetic is modulo 2^WIDTH.
  - Z = (result==0); N = result[WIDTH-1].
  - V for ADD = (a_msb==b_msb)&&(r_msb!=a_msb).
  - V for SUB = (a_msb!=b_msb)&&(r_msb!=a_msb).
  - V for AND and MVN = 0.
- SUB with write=0, loads=1 is the compare operation.
- rd may equal rn or rm. Both reads complete before the write.
- `start` while `busy`=1 is ignored. It is not queued.

## Timing
- Reset (synchronous, dominates `start`) sets:
  - all registers R[0..NREGS-1], A, B and C to 0
  - status to 000
  - state to IDLE
  - `busy`=0, `done`=0
- Reset mid-operation aborts the command with no register-file write. Outputs take their reset values in the cycle after the reset edge.
- `busy` is registered. It is 1 from the cycle after the accept edge through the WRITE cycle.
- `done` is registered. It is 1 for exactly one cycle, the cycle after WRITE, in which `busy`=0.
- ALU command latency: accept at edge 0 gives LOADA in cycle 1 and WRITE in cycle 4, with `done` high in cycle 5.
- Immediate command latency: WRITE in cycle 1, `done` high in cycle 2.
- A `start` in the `done` cycle is accepted. The throughput is one ALU command per 5 cycles.
- C and status update on the EXEC→WRITE edge. They are visible in the WRITE cycle and hold until the next EXEC.
- The register-file write takes effect on the WRITE→IDLE edge and is visible to the next command's LOADA.

## Configuration
- `DATAPATH_NV_FLAGS_EN`
  - Defined: status is the full {V,N,Z} as above.
  - Undefined: `status[2:1]` is tied to 0, V/N logic is not generated, and only Z is computed and registered. Port widths are unchanged.

## Test plan
All scenarios use WIDTH=16, NREGS=8.
- Reset, then immediate write R3 ← 0x0005 (vsel=1) → `done` 2 cycles after accept; a later ADD of R3+R3 gives `datapath_out`=0x000A.
- R1=0x0007, R2=0xFFFE; ADD rn=1, rm=2, shift=LSL1, rd=0, write=1, loads=1 → C=0x0003, status=000, R0=0x0003, `done` in cycle 5.
- R1=0x8000, R2=0x0001; SUB write=0, loads=1 → C=0x7FFF, status=100 (V=1), no register changed. With the macro undefined, status=000.
- `start` pulsed in cycles 1–4 of an in-flight command is ignored. `start` in the `done` cycle is accepted, and `busy` is 1 the next cycle.
- `reset` asserted during EXEC of a write=1 command → target register reads back 0. `busy`, `done`, status and C are 0, and no `done` pulse occurs.
- MVN with bsel=1, `datapath_in`=0x00FF, loads=1 → C=0xFF00, status=010 (N=1).

Source files
------------

// File: rtl/datapath_seq.sv
// datapath_seq: register file, A/B/C operand registers, B-path shifter,
// 4-op ALU and status register, driven by an internal micro-sequencer
// (IDLE -> LOADA -> LOADB -> EXEC -> WRITE, or IDLE -> WRITE for immediates).
// One accepted `start` runs a whole command and ends in a one-cycle `done`.
// Optional feature macro: DATAPATH_NV_FLAGS_EN (V/N status flags).
module datapath_seq #(
    parameter  int WIDTH = 16,
    parameter  int NREGS = 8,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RW-1:0]    cmd_rn,
    input  logic [RW-1:0]    cmd_rm,
    input  logic [RW-1:0]    cmd_rd,
    input  logic [1:0]       cmd_shift,
    input  logic [1:0]       cmd_aluop,
    input  logic             cmd_asel,
    input  logic             cmd_bsel,
    input  logic             cmd_vsel,
    input  logic             cmd_write,
    input  logic             cmd_loads,
    input  logic [WIDTH-1:0] datapath_in,
    output logic             busy,
    output logic             done,
    output logic [2:0]       status,
    output logic [WIDTH-1:0] datapath_out
);
    typedef enum logic [2:0] {S_IDLE, S_LOADA, S_LOADB, S_EXEC, S_WRITE} state_t;

    typedef struct packed {
        logic [RW-1:0]    rn;
        logic [RW-1:0]    rm;
        logic [RW-1:0]    rd;
        logic [1:0]       shift;
        logic [1:0]       aluop;
        logic             asel;
        logic             bsel;
        logic             vsel;
        logic             write;
        logic             loads;
        logic [WIDTH-1:0] imm;
    } cmd_t;

    state_t                       state;
    cmd_t                         cmd_q;
    logic [NREGS-1:0][WIDTH-1:0]  rf;
    logic [WIDTH-1:0]             a_q, b_q, c_q;
    logic [WIDTH-1:0]             bsh, ain, bin, alu_r;
    logic                         z_q;
    logic                         accept;

    // a command is only taken while the sequencer is idle; nothing is queued
    assign accept = start && (state == S_IDLE) && !reset;

    // capture the whole command on the accepting edge so later input
    // changes cannot disturb an in-flight operation
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q <= '{rn: cmd_rn, rm: cmd_rm, rd: cmd_rd, shift: cmd_shift,
                       aluop: cmd_aluop, asel: cmd_asel, bsel: cmd_bsel,
                       vsel: cmd_vsel, write: cmd_write, loads: cmd_loads,
                       imm: datapath_in};
        end
    end

    // B-path shifter, operand muxes and ALU
    always_comb begin
        case (cmd_q.shift)
            2'b00:   bsh = b_q;
            2'b01:   bsh = {b_q[WIDTH-2:0], 1'b0};
            2'b10:   bsh = {1'b0, b_q[WIDTH-1:1]};
            default: bsh = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
        endcase
        ain = cmd_q.asel ? '0 : a_q;
        bin = cmd_q.bsel ? cmd_q.imm : bsh;
        case (cmd_q.aluop)
            2'b00:   alu_r = ain + bin;
            2'b01:   alu_r = ain - bin;
            2'b10:   alu_r = ain & bin;
            default: alu_r = ~bin;
        endcase
    end

`ifdef DATAPATH_NV_FLAGS_EN
    logic v_flag, v_q, n_q;

    // signed overflow only exists for ADD/SUB
    always_comb begin
        v_flag = 1'b0;
        case (cmd_q.aluop)
            2'b00:   v_flag = (ain[WIDTH-1] == bin[WIDTH-1]) && (alu_r[WIDTH-1] != ain[WIDTH-1]);
            2'b01:   v_flag = (ain[WIDTH-1] != bin[WIDTH-1]) && (alu_r[WIDTH-1] != ain[WIDTH-1]);
            default: v_flag = 1'b0;
        endcase
    end

    // V/N flags follow Z: loaded on the EXEC->WRITE edge when loads=1
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else if (state == S_EXEC && cmd_q.loads) begin
            v_q <= v_flag;
            n_q <= alu_r[WIDTH-1];
        end
    end

    assign status = {v_q, n_q, z_q};
`else
    assign status = {2'b00, z_q};
`endif

    // micro-sequencer plus datapath registers; reset aborts any command
    // before its register-file write
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            rf    <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            z_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= cmd_vsel ? S_WRITE : S_LOADA;
                    end
                end
                S_LOADA: begin
                    a_q   <= rf[cmd_q.rn];
                    state <= S_LOADB;
                end
                S_LOADB: begin
                    b_q   <= rf[cmd_q.rm];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    c_q <= alu_r;
                    if (cmd_q.loads) z_q <= (alu_r == '0);
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (cmd_q.vsel)       rf[cmd_q.rd] <= cmd_q.imm;
                    else if (cmd_q.write) rf[cmd_q.rd] <= c_q;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign datapath_out = c_q;
endmodule

// File: tb/tb_datapath_seq.sv
// Directed bench for datapath_seq (WIDTH=16, NREGS=8). Register contents
// are observed through commands (ADD with asel=1 copies R[rm] into C).
module tb_datapath_seq;
    localparam int W = 16;
    localparam int N = 8;
`ifdef DATAPATH_NV_FLAGS_EN
    localparam bit NV = 1'b1;
`else
    localparam bit NV = 1'b0;
`endif
    localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, AND = 2'd2, MVN = 2'd3;
    localparam logic [1:0] NSH = 2'd0, LSL = 2'd1, LSR = 2'd2, ASR = 2'd3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   cmd_rn = '0, cmd_rm = '0, cmd_rd = '0;
    logic [1:0]   cmd_shift = '0, cmd_aluop = '0;
    logic         cmd_asel = 0, cmd_bsel = 0, cmd_vsel = 0, cmd_write = 0, cmd_loads = 0;
    logic [W-1:0] datapath_in = '0;
    logic         busy, done;
    logic [2:0]   status;
    logic [W-1:0] datapath_out;

    int n_checks = 0;
    int n_errs   = 0;
    int lat;
    logic [W-1:0] rv;
    int npulse;

    datapath_seq #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd),
        .cmd_shift(cmd_shift), .cmd_aluop(cmd_aluop),
        .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_vsel(cmd_vsel),
        .cmd_write(cmd_write), .cmd_loads(cmd_loads),
        .datapath_in(datapath_in),
        .busy(busy), .done(done), .status(status), .datapath_out(datapath_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected status for the current build: V/N vanish when the feature is off
    function automatic logic [2:0] st(input logic [2:0] s);
        return NV ? s : {2'b00, s[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] rd,
                           input logic [1:0] sh, input logic [1:0] op,
                           input logic asel, input logic bsel, input logic vsel,
                           input logic wr, input logic ld, input logic [W-1:0] imm);
        cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_shift = sh; cmd_aluop = op;
        cmd_asel = asel; cmd_bsel = bsel; cmd_vsel = vsel; cmd_write = wr;
        cmd_loads = ld; datapath_in = imm;
    endtask

    // pulse start, then count cycles until done (bounded); lat=1 is the
    // cycle right after the accept edge
    task automatic run(output int l);
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!done && l < 20) begin
            tick();
            l++;
        end
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [W-1:0] v);
        int l;
        set_cmd(3'd0, r, 3'd0, NSH, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run(l);
        chk("read_lat", l, 5);
        v = datapath_out;
    endtask

    task automatic imm_wr(input logic [2:0] rd, input logic [W-1:0] imm);
        int l;
        set_cmd(3'd0, 3'd0, rd, NSH, ADD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, imm);
        run(l);
        chk("imm_lat", l, 2);
    endtask

    initial begin
        // reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_dout", datapath_out, 0);

        // immediate write, then R3+R3
        imm_wr(3'd3, 16'h0005);
        chk("imm_busy_at_done", busy, 0);
        chk("imm_c_unchanged", datapath_out, 16'h0000);
        set_cmd(3'd3, 3'd3, 3'd0, NSH, ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        run(lat);
        chk("add33_lat", lat, 5);
        chk("add33_c", datapath_out, 16'h000A);
        chk("add33_st", status, st(3'b000));

        // ADD with LSL1 and carry out
        imm_wr(3'd1, 16'h0007);
        imm_wr(3'd2, 16'hFFFE);
        set_cmd(3'd1, 3'd2, 3'd0, LSL, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        run(lat);
        chk("addlsl_lat", lat, 5);
        chk("addlsl_c", datapath_out, 16'h0003);
        chk("addlsl_st", status, st(3'b000));
        read_reg(3'd0, rv);
        chk("addlsl_r0", rv, 16'h0003);

        // compare: SUB, write=0, signed overflow
        imm_wr(3'd1, 16'h8000);
        imm_wr(3'd2, 16'h0001);
        set_cmd(3'd1, 3'd2, 3'd1, NSH, SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        run(lat);
        chk("cmp_c", datapath_out, 16'h7FFF);
        chk("cmp_st", status, st(3'b100));
        read_reg(3'd1, rv);
        chk("cmp_r1_kept", rv, 16'h8000);
        chk("cmp_st_hold", status, st(3'b100));

        // shifts on a negative value
        imm_wr(3'd2, 16'h8001);
        set_cmd(3'd0, 3'd2, 3'd0, ASR, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run(lat);
        chk("asr_c", datapath_out, 16'hC000);
        set_cmd(3'd0, 3'd2, 3'd0, LSR, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        run(lat);
        chk("lsr_c", datapath_out, 16'h4000);

        // AND with immediate operand
        imm_wr(3'd7, 16'h0F0F);
        set_cmd(3'd7, 3'd0, 3'd0, NSH, AND, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h00FF);
        run(lat);
        chk("and_c", datapath_out, 16'h000F);

        // start while busy is ignored; start in the done cycle is accepted
        set_cmd(3'd3, 3'd3, 3'd4, NSH, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        start = 1'b1;
        tick();
        set_cmd(3'd0, 3'd0, 3'd5, LSL, SUB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234);
        tick(); tick(); tick();
        chk("ign_busy_wr", busy, 1);
        tick();
        chk("ign_done", done, 1);
        chk("ign_c", datapath_out, 16'h000A);
        set_cmd(3'd0, 3'd4, 3'd0, LSL, ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_done_low", done, 0);
        lat = 1;
        while (!done && lat < 20) begin tick(); lat++; end
        chk("b2b_lat", lat, 5);
        chk("b2b_r4", datapath_out, 16'h0014);
        read_reg(3'd5, rv);
        chk("ign_r5", rv, 16'h0000);

        // reset during EXEC of a write=1 command
        imm_wr(3'd6, 16'h0055);
        set_cmd(3'd6, 3'd6, 3'd6, NSH, ADD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, '0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_status", status, 0);
        chk("mid_dout", datapath_out, 0);
        npulse = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) npulse++;
            tick();
        end
        chk("mid_no_done", npulse, 0);
        read_reg(3'd6, rv);
        chk("mid_r6", rv, 16'h0000);

        // zero flag: R0 - R0
        set_cmd(3'd0, 3'd0, 3'd0, NSH, SUB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
        run(lat);
        chk("z_c", datapath_out, 16'h0000);
        chk("z_st", status, st(3'b001));

        // MVN of immediate
        set_cmd(3'd0, 3'd0, 3'd0, NSH, MVN, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h00FF);
        run(lat);
        chk("mvn_c", datapath_out, 16'hFF00);
        chk("mvn_st", status, st(3'b010));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
